// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, zero-latency imem fetch into a DEPTH-entry FIFO with redirect flush.
// Define FETCH_QUEUE_PERF_EN to get saturating fetch/stall counters; otherwise they read 0.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     w_clk,
    input  logic                     w_rst_n,
    output logic [31:0]              w_imem_adr,
    input  logic [31:0]              w_imem_ir,
    input  logic                     w_redirect,
    input  logic [31:0]              w_redirect_pc,
    output logic                     w_out_valid,
    input  logic                     w_out_ready,
    output logic [31:0]              w_out_pc,
    output logic [31:0]              w_out_ir,
    output logic [$clog2(DEPTH):0]   w_count,
    output logic [31:0]              w_fetch_cnt,
    output logic [31:0]              w_stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   ir_mem_q [DEPTH];
    logic          nonempty, push, pop;

    assign nonempty    = count_q != '0;
    assign w_out_valid = nonempty & ~w_redirect;
    assign pop         = w_out_valid & w_out_ready;
    assign push        = ~w_redirect & ((count_q < CW'(DEPTH)) | pop);
    assign w_imem_adr  = pc_q;
    assign w_count     = count_q;
    assign w_out_pc    = nonempty ? pc_mem_q[head_q] : '0;
    assign w_out_ir    = nonempty ? ir_mem_q[head_q] : '0;

    always_comb begin
        pc_d    = w_redirect ? (w_redirect_pc & 32'hFFFF_FFFC) : push ? pc_q + 32'd4 : pc_q;
        count_d = w_redirect ? '0 : count_q + CW'(push) - CW'(pop);
        head_d  = w_redirect ? '0 : head_q + AW'(pop);
        tail_d  = w_redirect ? '0 : tail_q + AW'(push);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge w_clk) begin
        if (push) begin
            pc_mem_q[tail_q] <= pc_q;
            ir_mem_q[tail_q] <= w_imem_ir;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] fetch_q, fetch_d, stall_q, stall_d;
    logic        stall;

    assign stall = (count_q == CW'(DEPTH)) & ~pop & ~w_redirect;

    always_comb begin
        fetch_d = (push  & ~&fetch_q) ? fetch_q + 32'd1 : fetch_q;
        stall_d = (stall & ~&stall_q) ? stall_q + 32'd1 : stall_q;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            stall_q <= stall_d;
        end
    end

    assign w_fetch_cnt = fetch_q;
    assign w_stall_cnt = stall_q;
`else
    assign w_fetch_cnt = '0;
    assign w_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of streaming, back-pressure, redirect, PC wrap and async reset.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_adr, imem_ir, redirect_pc, out_pc, out_ir, fetch_cnt, stall_cnt;
    logic        redirect = 1'b0, out_valid, out_ready = 1'b0;
    logic [2:0]  count;
    int          n_chk = 0, n_pass = 0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .w_clk(clk), .w_rst_n(rst_n), .w_imem_adr(imem_adr), .w_imem_ir(imem_ir),
        .w_redirect(redirect), .w_redirect_pc(redirect_pc), .w_out_valid(out_valid),
        .w_out_ready(out_ready), .w_out_pc(out_pc), .w_out_ir(out_ir), .w_count(count),
        .w_fetch_cnt(fetch_cnt), .w_stall_cnt(stall_cnt)
    );

    assign imem_ir = imem_adr ^ KEY;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        redirect_pc = 32'h0;
        #3;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_adr", imem_adr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_ir", out_ir, 32'h0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("t1_pre_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t1_valid", 32'(out_valid), 32'h1);
            check("t1_pc", out_pc, 32'(4 * i));
            check("t1_ir", out_ir, 32'(4 * i) ^ KEY);
        end

        out_ready = 1'b0;
        pulse_reset();
        check("t2_rst_count", 32'(count), 32'h0);
        for (int i = 0; i < 4; i++) step();
        check("t2_count", 32'(count), 32'h4);
        check("t2_adr", imem_adr, 32'd16);
        check("t2_pc", out_pc, 32'h0);
        for (int i = 0; i < 6; i++) step();
        check("t2_hold_count", 32'(count), 32'h4);
        check("t2_hold_adr", imem_adr, 32'd16);
        check("t2_hold_pc", out_pc, 32'h0);
        check("t2_stall", stall_cnt, PERF ? 32'd6 : 32'd0);
        check("t2_fetch", fetch_cnt, PERF ? 32'd4 : 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t3_count", 32'(count), 32'h4);
            check("t3_adr", imem_adr, 32'(16 + 4 * k));
            check("t3_pc", out_pc, 32'(4 * k));
        end
        check("t3_stall", stall_cnt, PERF ? 32'd6 : 32'd0);
        check("t3_fetch", fetch_cnt, PERF ? 32'd9 : 32'd0);

        out_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 3; i++) step();
        check("t4_count", 32'(count), 32'h3);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        out_ready = 1'b1;
        #1;
        check("t4_valid_redir", 32'(out_valid), 32'h0);
        step();
        redirect = 1'b0;
        check("t4_count0", 32'(count), 32'h0);
        check("t4_adr", imem_adr, 32'h100);
        check("t4_valid0", 32'(out_valid), 32'h0);
        step();
        check("t4_valid1", 32'(out_valid), 32'h1);
        check("t4_pc", out_pc, 32'h100);
        check("t4_ir", out_ir, 32'h100 ^ KEY);
        step();
        check("t4_pc2", out_pc, 32'h104);

        out_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("t5_adr", imem_adr, 32'hFFFF_FFFC);
        step();
        check("t5_pc", out_pc, 32'hFFFF_FFFC);
        check("t5_adr_wrap", imem_adr, 32'h0);
        step();
        check("t5_count", 32'(count), 32'h2);
        out_ready = 1'b1;
        step();
        check("t5_pc_wrap", out_pc, 32'h0);
        check("t5_ir_wrap", out_ir, KEY);
        check("t6_count2", 32'(count), 32'h2);

        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_count", 32'(count), 32'h0);
        check("t6_adr", imem_adr, 32'h0);
        check("t6_out_pc", out_pc, 32'h0);
        check("t6_fetch", fetch_cnt, 32'h0);
        check("t6_stall", stall_cnt, 32'h0);
        rst_n = 1'b1;
        step();
        check("t6_after", out_pc, 32'h0);
        check("t6_after_count", 32'(count), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
